bp_history_checkpoint_ctrl: RTL

- Controller that sequences the global branch-history shift register.
- Takes fetch-stage predictions and forwards them as shift-in commands.
- Checkpoints the pre-shift history of every in-flight branch in a circular buffer; resolves branches in program order.
- On a mispredict, flushes all in-flight checkpoints and issues a restore command (snapshot + actual outcome) to the history register.

---
 rtl/bp_history_checkpoint_ctrl.sv | 89 ++++++++
 1 files changed

// File: rtl/bp_history_checkpoint_ctrl.sv
// Sequences the global branch-history register: forwards fetch predictions as same-cycle shift commands and checkpoints pre-shift history per in-flight branch.
// Resolves in program order; a mispredict flushes every checkpoint and issues a restore (snapshot + actual outcome) combinationally.
module bp_history_checkpoint_ctrl #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 3,
  parameter int HIST_W = 32
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              pred_valid,
  input  logic              pred_taken,
  output logic              pred_ready,
  output logic [TAG_W-1:0]  pred_tag,
  input  logic [HIST_W-1:0] cur_history,
  input  logic              resolve_valid,
  input  logic              resolve_taken,
  output logic              resolve_ready,
  output logic              hist_predict_valid,
  output logic              hist_predict_taken,
  output logic              hist_train_mispredicted,
  output logic              hist_train_taken,
  output logic [HIST_W-1:0] hist_train_history,
  output logic [TAG_W:0]    inflight_count,
  output logic [15:0]       mispredict_count
);

  localparam logic [TAG_W:0] FULL = (TAG_W+1)'(DEPTH);

  logic [HIST_W-1:0] snapshot [DEPTH];
  logic [DEPTH-1:0]  pred_dir;
  logic [TAG_W-1:0]  head;
  logic [TAG_W-1:0]  tail;
  logic [TAG_W:0]    count;
  logic              res_fire;
  logic              mispredict;
  logic              pred_fire;

  assign pred_ready    = (count != FULL);
  assign resolve_ready = (count != '0);
  assign res_fire      = resolve_valid & resolve_ready;
  assign mispredict    = res_fire & (resolve_taken != pred_dir[head]);
  assign pred_fire     = pred_valid & pred_ready & ~mispredict;

  assign pred_tag       = tail;
  assign inflight_count = count;

  // Unqualified command payloads are forced to zero so the history register sees clean buses.
  assign hist_predict_valid      = pred_fire;
  assign hist_predict_taken      = pred_fire & pred_taken;
  assign hist_train_mispredicted = mispredict;
  assign hist_train_taken        = mispredict & resolve_taken;
  assign hist_train_history      = mispredict ? snapshot[head] : '0;

  // Slot contents need no reset: they are only read while count marks them valid.
  always_ff @(posedge clk) begin
    if (pred_fire) begin
      snapshot[tail] <= cur_history;
      pred_dir[tail] <= pred_taken;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      mispredict_count <= '0;
    end else if (mispredict) begin
      tail  <= head;
      count <= '0;
      if (mispredict_count != 16'hFFFF) begin
        mispredict_count <= mispredict_count + 16'd1;
      end
    end else begin
      if (res_fire) begin
        head <= head + TAG_W'(1);
      end
      if (pred_fire) begin
        tail <= tail + TAG_W'(1);
      end
      if (pred_fire && !res_fire) begin
        count <= count + (TAG_W+1)'(1);
      end else if (res_fire && !pred_fire) begin
        count <= count - (TAG_W+1)'(1);
      end
    end
  end

endmodule
